// File: rtl/mac_hst_arb.sv
// Host-port arbiter/sequencer for the 10G MAC: round-robin between ports A and B,
// runs one config-register or MDIO transaction at a time. Optional MDIO watchdog: MAC_HST_ARB_TIMEOUT_EN.
module mac_hst_arb #(
  parameter int CFG_RD_LAT  = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        host_clk,
  input  logic        host_reset,
  input  logic        a_req,
  input  logic [1:0]  a_opcode,
  input  logic [9:0]  a_addr,
  input  logic [31:0] a_wr_data,
  input  logic        a_miim_sel,
  output logic        a_ack,
  output logic        a_done,
  input  logic        b_req,
  input  logic [1:0]  b_opcode,
  input  logic [9:0]  b_addr,
  input  logic [31:0] b_wr_data,
  input  logic        b_miim_sel,
  output logic        b_ack,
  output logic        b_done,
  output logic [31:0] rd_data,
  output logic        err,
  output logic [1:0]  host_opcode,
  output logic [9:0]  host_addr,
  output logic [31:0] host_wr_data,
  output logic        host_miim_sel,
  output logic        host_req,
  input  logic [31:0] host_rd_data,
  input  logic        host_miim_rdy
);

  if (CFG_RD_LAT < 2 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("mac_hst_arb: CFG_RD_LAT must be >= 2 and TIMEOUT_CYC in 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE, ISSUE, CFG_WAIT, MDIO_RDY, MDIO_REQ, MDIO_GUARD, MDIO_WAIT, DONE
  } state_t;

  state_t      state, state_nx;
  logic        last_b, last_b_nx;
  logic        gnt_b, gnt_b_nx;
  logic [15:0] cnt, cnt_nx;
  logic        fin;
  logic        pick_b;

  logic [1:0]  cmd_opcode, cmd_opcode_nx;
  logic [9:0]  cmd_addr, cmd_addr_nx;
  logic [31:0] cmd_wr_data, cmd_wr_data_nx;
  logic        cmd_miim_sel, cmd_miim_sel_nx;

  logic        a_ack_nx, b_ack_nx, a_done_nx, b_done_nx;
  logic [31:0] rd_data_nx;
  logic [1:0]  host_opcode_nx;
  logic [9:0]  host_addr_nx;
  logic [31:0] host_wr_data_nx;
  logic        host_miim_sel_nx, host_req_nx;

`ifdef MAC_HST_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt, tmo_cnt_nx;
  logic        err_q, err_nx;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Both requesting: the side that did not win last time goes first.
  assign pick_b = b_req && (!a_req || !last_b);

  always_comb begin
    state_nx         = state;
    last_b_nx        = last_b;
    gnt_b_nx         = gnt_b;
    cnt_nx           = cnt;
    fin              = 1'b0;
    cmd_opcode_nx    = cmd_opcode;
    cmd_addr_nx      = cmd_addr;
    cmd_wr_data_nx   = cmd_wr_data;
    cmd_miim_sel_nx  = cmd_miim_sel;
    a_ack_nx         = 1'b0;
    b_ack_nx         = 1'b0;
    a_done_nx        = 1'b0;
    b_done_nx        = 1'b0;
    rd_data_nx       = rd_data;
    host_opcode_nx   = 2'b11;
    host_addr_nx     = '0;
    host_wr_data_nx  = '0;
    host_miim_sel_nx = 1'b0;
    host_req_nx      = 1'b0;
`ifdef MAC_HST_ARB_TIMEOUT_EN
    tmo_cnt_nx       = '0;
    err_nx           = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          gnt_b_nx        = pick_b;
          last_b_nx       = pick_b;
          cmd_opcode_nx   = pick_b ? b_opcode   : a_opcode;
          cmd_addr_nx     = pick_b ? b_addr     : a_addr;
          cmd_wr_data_nx  = pick_b ? b_wr_data  : a_wr_data;
          cmd_miim_sel_nx = pick_b ? b_miim_sel : a_miim_sel;
          a_ack_nx        = !pick_b;
          b_ack_nx        = pick_b;
          state_nx        = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nx = '0;
        if (cmd_miim_sel) begin
          host_miim_sel_nx = 1'b1;
          state_nx         = MDIO_RDY;
        end else begin
          host_opcode_nx  = cmd_opcode;
          host_addr_nx    = cmd_addr;
          host_wr_data_nx = cmd_wr_data;
          state_nx        = CFG_WAIT;
        end
      end
      CFG_WAIT: begin
        if (cnt == 16'(CFG_RD_LAT - 1)) begin
          if (cmd_opcode[1]) rd_data_nx = host_rd_data;
          fin = 1'b1;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      MDIO_RDY: begin
        host_miim_sel_nx = 1'b1;
        if (host_miim_rdy) begin
          host_req_nx     = 1'b1;
          host_opcode_nx  = cmd_opcode;
          host_addr_nx    = cmd_addr;
          host_wr_data_nx = {16'b0, cmd_wr_data[15:0]};
          state_nx        = MDIO_REQ;
        end
`ifdef MAC_HST_ARB_TIMEOUT_EN
        else if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
          fin        = 1'b1;
          err_nx     = 1'b1;
          rd_data_nx = 32'hDEAD_0000;
        end else begin
          tmo_cnt_nx = tmo_cnt + 16'd1;
        end
`endif
      end
      MDIO_REQ: begin
        host_miim_sel_nx = 1'b1;
        cnt_nx           = '0;
        state_nx         = MDIO_GUARD;
      end
      MDIO_GUARD: begin
        // The MAC may still show rdy from the previous access; ignore it here.
        host_miim_sel_nx = 1'b1;
        if (cnt == 16'd1) state_nx = MDIO_WAIT;
        else              cnt_nx   = cnt + 16'd1;
      end
      MDIO_WAIT: begin
        host_miim_sel_nx = 1'b1;
        if (host_miim_rdy) begin
          if (cmd_opcode[1]) rd_data_nx = {16'b0, host_rd_data[15:0]};
          fin = 1'b1;
        end
`ifdef MAC_HST_ARB_TIMEOUT_EN
        else if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
          fin        = 1'b1;
          err_nx     = 1'b1;
          rd_data_nx = 32'hDEAD_0000;
        end else begin
          tmo_cnt_nx = tmo_cnt + 16'd1;
        end
`endif
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (fin) begin
      state_nx         = DONE;
      a_done_nx        = !gnt_b;
      b_done_nx        = gnt_b;
      host_miim_sel_nx = 1'b0;
    end
  end

  always_ff @(posedge host_clk) begin
    if (host_reset) begin
      state         <= IDLE;
      last_b        <= 1'b1;
      gnt_b         <= 1'b0;
      cnt           <= '0;
      a_ack         <= 1'b0;
      b_ack         <= 1'b0;
      a_done        <= 1'b0;
      b_done        <= 1'b0;
      rd_data       <= '0;
      host_opcode   <= 2'b11;
      host_addr     <= '0;
      host_wr_data  <= '0;
      host_miim_sel <= 1'b0;
      host_req      <= 1'b0;
`ifdef MAC_HST_ARB_TIMEOUT_EN
      tmo_cnt       <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state         <= state_nx;
      last_b        <= last_b_nx;
      gnt_b         <= gnt_b_nx;
      cnt           <= cnt_nx;
      a_ack         <= a_ack_nx;
      b_ack         <= b_ack_nx;
      a_done        <= a_done_nx;
      b_done        <= b_done_nx;
      rd_data       <= rd_data_nx;
      host_opcode   <= host_opcode_nx;
      host_addr     <= host_addr_nx;
      host_wr_data  <= host_wr_data_nx;
      host_miim_sel <= host_miim_sel_nx;
      host_req      <= host_req_nx;
`ifdef MAC_HST_ARB_TIMEOUT_EN
      tmo_cnt       <= tmo_cnt_nx;
      err_q         <= err_nx;
`endif
    end
  end

  // Latched command fields are pure data and need no reset.
  always_ff @(posedge host_clk) begin
    cmd_opcode   <= cmd_opcode_nx;
    cmd_addr     <= cmd_addr_nx;
    cmd_wr_data  <= cmd_wr_data_nx;
    cmd_miim_sel <= cmd_miim_sel_nx;
  end

endmodule

// File: doc/mac_hst_arb.md
# mac_hst_arb

Arbiter and sequencer for the 10G MAC host configuration interface. It shares one host port between two requesters: port A (host/driver MDIO and config accesses decoded from PCIe TLPs) and port B (on-chip link-status poller). It runs each granted command as a complete config-register or MDIO transaction and returns read data with a completion pulse. It sits between the requesters and the MAC host interface, in the `host_clk` domain.

## Interface
Parameters:
- `CFG_RD_LAT`, 2: cycles from config-register command issue to valid `host_rd_data`.
- `TIMEOUT_CYC`, 50000: MDIO completion watchdog limit, in `host_clk` cycles. Used only with `MAC_HST_ARB_TIMEOUT_EN`.

Ports:
- `host_clk` in 1: the single clock.
- `host_reset` in 1: synchronous, active-high reset.
- `a_req`, `b_req` in 1: command request.
- `a_opcode`, `b_opcode` in 2: `[1]=1` read, `[1]=0` write. For MDIO, the full MAC opcode.
- `a_addr`, `b_addr` in 10: register address, or MDIO port/dev address.
- `a_wr_data`, `b_wr_data` in 32: write data. MDIO uses `[15:0]`.
- `a_miim_sel`, `b_miim_sel` in 1: 1 = MDIO transaction, 0 = config register.
- `a_ack`, `b_ack` out 1: 1-cycle pulse; command latched.
- `a_done`, `b_done` out 1: 1-cycle pulse; transaction complete.
- `rd_data` out 32: read result, valid in the `*_done` cycle. Holds until the next done.
- `err` out 1: valid with `*_done`. 1 = timeout.
- `host_opcode` out 2, `host_addr` out 10, `host_wr_data` out 32, `host_miim_sel` out 1, `host_req` out 1: MAC host port.
- `host_rd_data` in 32, `host_miim_rdy` in 1: MAC host port.

## Operation
- Reset values:
  - `host_opcode=2'b11`, `host_addr=0`, `host_wr_data=0`, `host_miim_sel=0`, `host_req=0`.
  - `a_ack`, `b_ack`, `a_done`, `b_done`, `err` = 0; `rd_data=0`.
  - FSM in IDLE; `last_grant=B`, so A wins the first tie.
- Idle host drive: in every non-issue state, host outputs return to the reset values, except `host_miim_sel`, which holds during MDIO states.
- Arbitration (IDLE only): round-robin over the two requesters.
  - If exactly one `*_req` is high, that requester wins.
  - If both are high, the side not equal to `last_grant` wins.
  - On grant: latch that side's opcode/addr/wr_data/miim_sel, pulse `*_ack`, update `last_grant`, go to ISSUE.
- FSM states: IDLE, ISSUE, CFG_WAIT, MDIO_RDY, MDIO_REQ, MDIO_GUARD, MDIO_WAIT, DONE.
  - ISSUE: if `miim_sel=0`, drive the latched fields with `host_miim_sel=0` for exactly 1 cycle, then go to CFG_WAIT. If `miim_sel=1`, go to MDIO_RDY.
  - CFG_WAIT: count `CFG_RD_LAT-1` cycles, capture `host_rd_data` into `rd_data` (reads only; writes leave `rd_data` unchanged), then go to DONE.
  - MDIO_RDY: `host_miim_sel=1`; wait for `host_miim_rdy=1`, then go to MDIO_REQ.
  - MDIO_REQ: drive opcode/addr/`wr_data[15:0]` with `host_req=1` for 1 cycle, then go to MDIO_GUARD.
  - MDIO_GUARD: 2 cycles with `host_req=0`, ignoring `host_miim_rdy`, then go to MDIO_WAIT.
  - MDIO_WAIT: on `host_miim_rdy=1`, set `rd_data={16'b0, host_rd_data[15:0]}` (reads only), then go to DONE.
  - DONE: pulse the granted side's `*_done` with `err`; return to IDLE.
- Requester rule: `*_req` must be low in the cycle after `*_ack`. A high `*_req` in IDLE is always a new command.
- Only one transaction is ever outstanding. A request that arrives mid-transaction waits in IDLE arbitration.
- Reset mid-transaction: abort immediately; all outputs go to reset values and no `*_done` is issued.

## Timing
- Grant: `*_ack` is asserted in the cycle after the `*_req` is seen in IDLE.
- Config write: ack at T, host issue at T+1, done at T+1+CFG_RD_LAT.
- Config read: same timing as config write, with `rd_data` valid at done.
- MDIO with `host_miim_rdy` already high: ack at T, `host_req` at T+2, done no earlier than T+6.
- Back-to-back: minimum 1 IDLE cycle between a done and the next ack.

## Configuration
- `MAC_HST_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter runs in MDIO_RDY and MDIO_WAIT.
  - Reaching `TIMEOUT_CYC` forces DONE with `err=1`, `rd_data=32'hDEAD_0000`.
  - Host outputs return to the idle drive and `host_miim_sel` drops to 0.
- Not defined: no counter; MDIO waits are unbounded; `err` is tied to 0.

## Test plan
- Config write, A only (`addr=10'h240`, `wr_data=32'h1E00_0000`, `miim_sel=0`) -> one-cycle host issue with those values; `a_done` 1+CFG_RD_LAT cycles after `a_ack`; `err=0`.
- Config read, B (`addr=10'h340`), model returns `32'h0000_0029` -> `b_done` with `rd_data=32'h0000_0029`.
- MDIO read, A (`opcode=2'b11`, `addr=10'h081`), model drops rdy for 10 cycles then returns `16'h1234` -> single `host_req` pulse; `a_done`, `rd_data=32'h0000_1234`.
- A and B request in the same cycle, repeated 4 times -> grants alternate A, B, A, B; never two grants outstanding.
- Reset asserted during MDIO_WAIT -> next cycle all outputs are at reset values and no done pulse occurs; then a fresh A request completes normally.
- With `MAC_HST_ARB_TIMEOUT_EN`, `TIMEOUT_CYC=100`, and rdy held low -> `*_done` with `err=1`, `rd_data=32'hDEAD_0000`, about 100 cycles after entering the wait.
